// File: rtl/axi4_assertion_pkg.sv
// Burst/response encodings, error-bit positions and burst-shape helpers
// shared by the AXI4 protocol checker.
package axi4_assertion_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  localparam int ERR_W             = 16;
  localparam int ERR_AW_STABLE     = 0;
  localparam int ERR_W_STABLE      = 1;
  localparam int ERR_B_STABLE      = 2;
  localparam int ERR_AR_STABLE     = 3;
  localparam int ERR_R_STABLE      = 4;
  localparam int ERR_AW_BURST_RSVD = 5;
  localparam int ERR_AR_BURST_RSVD = 6;
  localparam int ERR_AW_SIZE       = 7;
  localparam int ERR_AR_SIZE       = 8;
  localparam int ERR_AW_WRAP       = 9;
  localparam int ERR_AR_WRAP       = 10;
  localparam int ERR_AW_4K         = 11;
  localparam int ERR_AR_4K         = 12;
  localparam int ERR_WLAST         = 13;
  localparam int ERR_RLAST         = 14;
  localparam int ERR_ORDER         = 15;

  // Largest span is 4095 + 256*128, so 17 bits never overflow.
  function automatic logic crosses_4k(input logic [11:0] offset, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [16:0] span;
    span = (17'(len) + 17'd1) << size;
    return (17'(offset) + span) > 17'd4096;
  endfunction

  function automatic logic wrap_shape_bad(input logic [7:0] len, input logic [6:0] addr_lo,
                                          input logic [2:0] size);
    logic       len_ok;
    logic [6:0] mask;
    len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    mask   = (7'd1 << size) - 7'd1;
    return !len_ok || ((addr_lo & mask) != 7'd0);
  endfunction

endpackage

// File: rtl/axi4_len_fifo.sv
// Small FIFO of burst lengths; a push and pop in the same cycle always succeed,
// even when empty (value passes straight through) or full.
module axi4_len_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [7:0]       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign head    = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/axi4_assertion.sv
// Passive AXI4 protocol checker: flags handshake stability, burst shape,
// WLAST/RLAST placement and response ordering as pulsed/sticky/counted bits.
module axi4_assertion
  import axi4_assertion_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  input  logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  input  logic              rready,
  output logic [15:0]       err_now,
  output logic [15:0]       err_flags,
  output logic [15:0]       err_count
);
  localparam int AX_PL_W = ADDR_W + 13;
  localparam int W_PL_W  = DATA_W + STRB_W + 1;
  localparam int PL_W    = (AX_PL_W > W_PL_W) ? AX_PL_W : W_PL_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wlast_hs, rlast_hs;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready;
  assign ar_hs    = arvalid && arready;
  assign r_hs     = rvalid && rready;
  assign wlast_hs = w_hs && wlast;
  assign rlast_hs = r_hs && rlast;

  // Channel order 0..4 = AW, W, B, AR, R, matching the stability error bits.
  logic [4:0]      ch_valid, ch_ready, stable_err;
  logic [PL_W-1:0] ch_payload [5];
  assign ch_valid      = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign ch_ready      = {rready, arready, bready, wready, awready};
  assign ch_payload[0] = PL_W'({awaddr, awlen, awsize, awburst});
  assign ch_payload[1] = PL_W'({wdata, wstrb, wlast});
  assign ch_payload[2] = PL_W'(bresp);
  assign ch_payload[3] = PL_W'({araddr, arlen, arsize, arburst});
  assign ch_payload[4] = PL_W'({rdata, rresp, rlast});

  for (genvar gi = 0; gi < 5; gi++) begin : g_stable
    logic            stall_reg;
    logic [PL_W-1:0] saved_reg;
    always_ff @(posedge aclk) begin
      if (areset) begin
        stall_reg <= 1'b0;
        saved_reg <= '0;
      end else begin
        stall_reg <= ch_valid[gi] && !ch_ready[gi];
        saved_reg <= ch_payload[gi];
      end
    end
    assign stable_err[gi] = stall_reg && (!ch_valid[gi] || (ch_payload[gi] != saved_reg));
  end

  // Address-channel shape rules, index 0 = AW, 1 = AR; checked on every valid cycle.
  logic [1:0]  ax_valid, rsvd_err, size_err, wrap_err, cross_err;
  logic [11:0] ax_addr_lo [2];
  logic [7:0]  ax_len [2];
  logic [2:0]  ax_size [2];
  logic [1:0]  ax_burst [2];
  assign ax_valid      = {arvalid, awvalid};
  assign ax_addr_lo[0] = awaddr[11:0];
  assign ax_addr_lo[1] = araddr[11:0];
  assign ax_len[0]     = awlen;
  assign ax_len[1]     = arlen;
  assign ax_size[0]    = awsize;
  assign ax_size[1]    = arsize;
  assign ax_burst[0]   = awburst;
  assign ax_burst[1]   = arburst;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ax_rules
    assign rsvd_err[gi]  = ax_valid[gi] && (ax_burst[gi] == BURST_RSVD);
    assign size_err[gi]  = ax_valid[gi] && ((9'd1 << ax_size[gi]) > 9'(STRB_W));
    assign wrap_err[gi]  = ax_valid[gi] && (ax_burst[gi] == BURST_WRAP) &&
                           wrap_shape_bad(ax_len[gi], ax_addr_lo[gi][6:0], ax_size[gi]);
    assign cross_err[gi] = ax_valid[gi] && (ax_burst[gi] == BURST_INCR) &&
                           crosses_4k(ax_addr_lo[gi], ax_len[gi], ax_size[gi]);
  end

  logic       aw_full, aw_empty, ar_full, ar_empty;
  logic [7:0] aw_head, ar_head;

  axi4_len_fifo #(.DEPTH(DEPTH)) u_aw_len_fifo (
    .clk(aclk), .srst(areset), .push(aw_hs), .push_data(awlen), .pop(wlast_hs),
    .full(aw_full), .empty(aw_empty), .head(aw_head)
  );

  axi4_len_fifo #(.DEPTH(DEPTH)) u_ar_len_fifo (
    .clk(aclk), .srst(areset), .push(ar_hs), .push_data(arlen), .pop(rlast_hs),
    .full(ar_full), .empty(ar_empty), .head(ar_head)
  );

  // Data-beat placement, index 0 = W against AW lengths, 1 = R against AR lengths.
  logic [1:0] d_hs, d_last, a_hs, f_empty, have_len, last_err;
  logic [7:0] a_len [2];
  logic [7:0] f_head [2];
  assign d_hs      = {r_hs, w_hs};
  assign d_last    = {rlast, wlast};
  assign a_hs      = {ar_hs, aw_hs};
  assign f_empty   = {ar_empty, aw_empty};
  assign a_len[0]  = awlen;
  assign a_len[1]  = arlen;
  assign f_head[0] = aw_head;
  assign f_head[1] = ar_head;

  for (genvar gi = 0; gi < 2; gi++) begin : g_last
    logic [7:0] beat_reg;
    logic [7:0] exp_len;
    assign have_len[gi] = !f_empty[gi] || a_hs[gi];
    assign exp_len      = f_empty[gi] ? a_len[gi] : f_head[gi];
    assign last_err[gi] = d_hs[gi] && (d_last[gi] ? (!have_len[gi] || (beat_reg != exp_len))
                                                  : (have_len[gi] && (beat_reg == exp_len)));
    always_ff @(posedge aclk) begin
      if (areset)        beat_reg <= '0;
      else if (d_hs[gi]) beat_reg <= d_last[gi] ? 8'd0 : beat_reg + 8'd1;
    end
  end

  logic [CNT_W-1:0] wr_done_reg, wr_done_next;
  always_comb begin
    wr_done_next = wr_done_reg;
    if (wlast_hs && !b_hs && (wr_done_reg != CNT_W'(DEPTH))) wr_done_next = wr_done_reg + 1'b1;
    if (b_hs && !wlast_hs && (wr_done_reg != '0))            wr_done_next = wr_done_reg - 1'b1;
  end

  logic [15:0] err_vec;
  always_comb begin
    err_vec = '0;
    err_vec[ERR_AW_STABLE]     = stable_err[0];
    err_vec[ERR_W_STABLE]      = stable_err[1];
    err_vec[ERR_B_STABLE]      = stable_err[2];
    err_vec[ERR_AR_STABLE]     = stable_err[3];
    err_vec[ERR_R_STABLE]      = stable_err[4];
    err_vec[ERR_AW_BURST_RSVD] = rsvd_err[0];
    err_vec[ERR_AR_BURST_RSVD] = rsvd_err[1];
    err_vec[ERR_AW_SIZE]       = size_err[0];
    err_vec[ERR_AR_SIZE]       = size_err[1];
    err_vec[ERR_AW_WRAP]       = wrap_err[0];
    err_vec[ERR_AR_WRAP]       = wrap_err[1];
    err_vec[ERR_AW_4K]         = cross_err[0];
    err_vec[ERR_AR_4K]         = cross_err[1];
    err_vec[ERR_WLAST]         = last_err[0];
    err_vec[ERR_RLAST]         = last_err[1] || (rvalid && !have_len[1]);
    err_vec[ERR_ORDER]         = (bvalid && (wr_done_reg == '0) && !wlast_hs) ||
                                 (aw_hs && aw_full && !wlast_hs) ||
                                 (ar_hs && ar_full && !rlast_hs);
  end

  // Flags and count track err_vec directly so all three outputs move on the same edge.
  logic [15:0] err_now_reg, err_flags_reg, err_count_reg;
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_now_reg   <= '0;
      err_flags_reg <= '0;
      err_count_reg <= '0;
      wr_done_reg   <= '0;
    end else begin
      err_now_reg   <= err_vec;
      err_flags_reg <= err_flags_reg | err_vec;
      wr_done_reg   <= wr_done_next;
      if ((err_vec != '0) && (err_count_reg != 16'hFFFF)) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign err_now   = err_now_reg;
  assign err_flags = err_flags_reg;
  assign err_count = err_count_reg;
endmodule

// File: tb/tb_axi4_assertion.sv
// Directed and randomized bench for axi4_assertion against a queue-based model
// of the protocol rules; one line per scenario plus a final summary.
module tb_axi4_assertion;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int STRB_W = DATA_W / 8;

  logic aclk = 1'b0;
  logic areset;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic [15:0] err_now, err_flags, err_count;

  axi4_assertion #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_now(err_now), .err_flags(err_flags), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  int aw_q[$];
  int ar_q[$];
  int w_beats, r_beats, wr_done;
  logic [15:0] m_flags, m_count;
  logic p_aw_stall, p_w_stall, p_b_stall, p_ar_stall, p_r_stall;
  logic [ADDR_W-1:0] p_awaddr, p_araddr;
  logic [7:0]  p_awlen, p_arlen;
  logic [2:0]  p_awsize, p_arsize;
  logic [1:0]  p_awburst, p_arburst, p_bresp, p_rresp;
  logic [DATA_W-1:0] p_wdata, p_rdata;
  logic [STRB_W-1:0] p_wstrb;
  logic p_wlast, p_rlast;

  // {4k, wrap, size, reserved} for one address-channel request
  function automatic logic [3:0] ax_rules(input logic v, input logic [ADDR_W-1:0] addr,
                                          input int len, input int size, input int burst);
    logic [3:0] r;
    int bytes;
    r = 4'b0000;
    bytes = 1 << size;
    if (v) begin
      r[0] = (burst == 3);
      r[1] = (bytes > STRB_W);
      r[2] = (burst == 2) && (!(len inside {1, 3, 7, 15}) || ((int'(addr[6:0]) % bytes) != 0));
      r[3] = (burst == 1) && ((int'(addr[11:0]) + (len + 1) * bytes) > 4096);
    end
    return r;
  endfunction

  task automatic step(input string tag);
    logic [15:0] e;
    logic [3:0]  rw, rr;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, wl, rl;
    int exp_w, exp_r;
    logic aw_bypass, aw_drop, ar_bypass, ar_drop;
    e = '0;
    if (areset) begin
      aw_q.delete(); ar_q.delete();
      w_beats = 0; r_beats = 0; wr_done = 0;
      m_flags = '0; m_count = '0;
      p_aw_stall = 0; p_w_stall = 0; p_b_stall = 0; p_ar_stall = 0; p_r_stall = 0;
    end else begin
      e[0] = p_aw_stall && (!awvalid || awaddr != p_awaddr || awlen != p_awlen ||
                            awsize != p_awsize || awburst != p_awburst);
      e[1] = p_w_stall && (!wvalid || wdata != p_wdata || wstrb != p_wstrb || wlast != p_wlast);
      e[2] = p_b_stall && (!bvalid || bresp != p_bresp);
      e[3] = p_ar_stall && (!arvalid || araddr != p_araddr || arlen != p_arlen ||
                            arsize != p_arsize || arburst != p_arburst);
      e[4] = p_r_stall && (!rvalid || rdata != p_rdata || rresp != p_rresp || rlast != p_rlast);
      rw = ax_rules(awvalid, awaddr, int'(awlen), int'(awsize), int'(awburst));
      rr = ax_rules(arvalid, araddr, int'(arlen), int'(arsize), int'(arburst));
      e[5] = rw[0]; e[6] = rr[0]; e[7] = rw[1]; e[8] = rr[1];
      e[9] = rw[2]; e[10] = rr[2]; e[11] = rw[3]; e[12] = rr[3];
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      wl = w_hs && wlast; rl = r_hs && rlast;
      exp_w = (aw_q.size() > 0) ? aw_q[0] : (aw_hs ? int'(awlen) : -1);
      exp_r = (ar_q.size() > 0) ? ar_q[0] : (ar_hs ? int'(arlen) : -1);
      if (w_hs) e[13] = wlast ? ((exp_w < 0) || (w_beats != exp_w)) : ((exp_w >= 0) && (w_beats == exp_w));
      if (r_hs) e[14] = rlast ? ((exp_r < 0) || (r_beats != exp_r)) : ((exp_r >= 0) && (r_beats == exp_r));
      if (rvalid && ar_q.size() == 0 && !ar_hs) e[14] = 1'b1;
      e[15] = (bvalid && wr_done == 0 && !wl) ||
              (aw_hs && aw_q.size() == DEPTH && !wl) ||
              (ar_hs && ar_q.size() == DEPTH && !rl);
      // advance model
      aw_bypass = wl && aw_q.size() == 0 && aw_hs;
      aw_drop   = aw_hs && aw_q.size() == DEPTH && !wl;
      ar_bypass = rl && ar_q.size() == 0 && ar_hs;
      ar_drop   = ar_hs && ar_q.size() == DEPTH && !rl;
      if (wl && aw_q.size() > 0) void'(aw_q.pop_front());
      if (aw_hs && !aw_bypass && !aw_drop) aw_q.push_back(int'(awlen));
      if (rl && ar_q.size() > 0) void'(ar_q.pop_front());
      if (ar_hs && !ar_bypass && !ar_drop) ar_q.push_back(int'(arlen));
      if (w_hs) w_beats = wlast ? 0 : (w_beats + 1) % 256;
      if (r_hs) r_beats = rlast ? 0 : (r_beats + 1) % 256;
      wr_done = wr_done + int'(wl) - int'(b_hs);
      if (wr_done < 0) wr_done = 0;
      if (wr_done > DEPTH) wr_done = DEPTH;
      m_flags = m_flags | e;
      if (e != 0 && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      p_aw_stall = awvalid && !awready; p_w_stall = wvalid && !wready; p_b_stall = bvalid && !bready;
      p_ar_stall = arvalid && !arready; p_r_stall = rvalid && !rready;
      p_awaddr = awaddr; p_awlen = awlen; p_awsize = awsize; p_awburst = awburst;
      p_wdata = wdata; p_wstrb = wstrb; p_wlast = wlast; p_bresp = bresp;
      p_araddr = araddr; p_arlen = arlen; p_arsize = arsize; p_arburst = arburst;
      p_rdata = rdata; p_rresp = rresp; p_rlast = rlast;
    end
    @(posedge aclk);
    #1;
    check({tag, ".now"}, err_now, e);
    check({tag, ".flags"}, err_flags, m_flags);
    check({tag, ".count"}, err_count, m_count);
  endtask

  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
  endtask

  task automatic do_reset();
    areset = 1; idle();
    step("rst"); step("rst");
    check("rst.zero_now", err_now, 16'h0000);
    check("rst.zero_count", err_count, 16'h0000);
    areset = 0;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    awvalid = 1; awaddr = a; awlen = l; awsize = s; awburst = b;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    arvalid = 1; araddr = a; arlen = l; arsize = s; arburst = b;
  endtask

  task automatic legal_write(input logic [7:0] len);
    set_aw(32'h100, len, 3'd2, 2'b01); awready = 1; step("lw.aw"); awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wready = 1; wdata = $urandom; wstrb = 4'hF; wlast = (i == int'(len));
      step("lw.w");
    end
    wvalid = 0; wlast = 0; bvalid = 1; bready = 1; bresp = 2'b00; step("lw.b");
    bvalid = 0; step("lw.idle");
  endtask

  function automatic logic [7:0] rnd_len();
    int k;
    k = $urandom_range(0, 5);
    case (k)
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd3;
      3: return 8'd7;
      4: return 8'd15;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    areset = 1; idle();
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0; bresp = '0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; rdata = '0; rresp = '0;

    // Legal INCR write: 4 beats then one B
    do_reset();
    legal_write(8'd3);
    check("s1.flags_clean", err_flags, 16'h0000);
    $display("S1 legal INCR write addr=0x100 len=3: flags=%h", err_flags);

    // AW payload changes while stalled
    do_reset();
    set_aw(32'h100, 8'd0, 3'd2, 2'b01); awready = 0; step("s2.stall");
    awaddr = 32'h104; step("s2.change");
    check("s2.pulse", err_now, 16'h0001);
    awready = 1; step("s2.accept");
    check("s2.once", err_now, 16'h0000);
    awvalid = 0; step("s2.idle");
    check("s2.flags", err_flags, 16'h0001);
    check("s2.count", err_count, 16'h0001);
    $display("S2 AW stall with addr change: flags=%h count=%0d", err_flags, err_count);

    // AR 4KB crossing vs. not crossing
    do_reset();
    set_ar(32'hFF0, 8'd7, 3'd2, 2'b01); arready = 1; step("s3.cross");
    check("s3.cross_bit", err_now, 16'h1000);
    araddr = 32'hF00; step("s3.nocross");
    check("s3.nocross_bit", err_now, 16'h0000);
    arvalid = 0; step("s3.idle");
    $display("S3 AR 4KB check: flags=%h", err_flags);

    // WRAP shape violations
    do_reset();
    set_aw(32'h100, 8'd2, 3'd2, 2'b10); awready = 1; step("s4.len");
    check("s4.wrap_len", err_now, 16'h0200);
    set_aw(32'h102, 8'd3, 3'd2, 2'b10); step("s4.align");
    check("s4.wrap_align", err_now, 16'h0200);
    awvalid = 0; step("s4.idle");
    $display("S4 WRAP shape checks: flags=%h", err_flags);

    // Early RLAST, orphan R, early B
    do_reset();
    set_ar(32'h0, 8'd3, 3'd2, 2'b01); arready = 1; step("s5.ar"); arvalid = 0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1; rready = 1; rdata = $urandom; rresp = 2'b00; rlast = (i == 2);
      step("s5.r");
    end
    check("s5.early_rlast", err_now, 16'h4000);
    rlast = 0; step("s5.orphan");
    check("s5.orphan_r", err_now, 16'h4000);
    rvalid = 0; bvalid = 1; bready = 1; step("s5.b");
    check("s5.early_b", err_now, 16'h8000);
    bvalid = 0; step("s5.idle");
    $display("S5 read/response ordering: flags=%h count=%0d", err_flags, err_count);

    // Reset mid-burst discards tracking
    set_aw(32'h200, 8'd3, 3'd2, 2'b01); awready = 1; step("s6.aw"); awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1; wready = 1; wdata = $urandom; wstrb = 4'hF; wlast = 0; step("s6.w");
    end
    wvalid = 0; areset = 1; step("s6.rst");
    check("s6.rst_now", err_now, 16'h0000);
    check("s6.rst_flags", err_flags, 16'h0000);
    check("s6.rst_count", err_count, 16'h0000);
    areset = 0;
    legal_write(8'd1);
    set_ar(32'h40, 8'd0, 3'd2, 2'b01); arready = 1; step("s6.ar"); arvalid = 0;
    rvalid = 1; rready = 1; rlast = 1; rdata = $urandom; step("s6.r");
    rvalid = 0; rlast = 0; step("s6.idle");
    check("s6.after_flags", err_flags, 16'h0000);
    check("s6.after_count", err_count, 16'h0000);
    $display("S6 reset mid-burst then legal traffic: flags=%h count=%0d", err_flags, err_count);

    // FIFO overflow and push+pop on full
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_aw(32'h0, 8'd0, 3'd2, 2'b01); awready = 1; step("s7.fill");
    end
    step("s7.over");
    check("s7.overflow", err_now, 16'h8000);
    wvalid = 1; wready = 1; wlast = 1; wstrb = 4'hF; wdata = $urandom; step("s7.pushpop");
    check("s7.push_pop_full", err_now, 16'h0000);
    idle(); step("s7.idle");
    $display("S7 AW length FIFO full: flags=%h", err_flags);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      areset = ($urandom_range(0, 399) == 0);
      if (!(p_aw_stall && $urandom_range(0, 9) != 0)) begin
        awvalid = ($urandom_range(0, 2) == 0);
        awaddr = 32'($urandom_range(0, 32'h2FFF)); awlen = rnd_len();
        awsize = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        awburst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      awready = 1'($urandom_range(0, 1));
      if (!(p_w_stall && $urandom_range(0, 9) != 0)) begin
        wvalid = 1'($urandom_range(0, 1)); wdata = $urandom; wstrb = 4'($urandom);
        wlast = ($urandom_range(0, 2) == 0);
      end
      wready = 1'($urandom_range(0, 1));
      if (!(p_b_stall && $urandom_range(0, 9) != 0)) begin
        bvalid = ($urandom_range(0, 3) == 0); bresp = 2'($urandom_range(0, 3));
      end
      bready = 1'($urandom_range(0, 1));
      if (!(p_ar_stall && $urandom_range(0, 9) != 0)) begin
        arvalid = ($urandom_range(0, 2) == 0);
        araddr = 32'($urandom_range(0, 32'h2FFF)); arlen = rnd_len();
        arsize = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        arburst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      end
      arready = 1'($urandom_range(0, 1));
      if (!(p_r_stall && $urandom_range(0, 9) != 0)) begin
        rvalid = 1'($urandom_range(0, 1)); rdata = $urandom; rresp = 2'($urandom_range(0, 3));
        rlast = ($urandom_range(0, 2) == 0);
      end
      rready = 1'($urandom_range(0, 1));
      step("rnd");
    end
    $display("S8 random traffic 3000 cycles: flags=%h count=%0d", err_flags, err_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_assertion.md
AXI4_ASSERTION -- requirements
Module: axi4_assertion

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width; legal values are 8 to 1024 in powers of 2; STRB_W = DATA_W/8.
REQ-003 The block SHALL have parameter DEPTH, default 8, outstanding-burst tracking depth per direction.
REQ-004 Port aclk: input, 1 bit; the single clock; all logic SHALL be on its rising edge.
REQ-005 Port areset: input, 1 bit; reset SHALL be synchronous and active-high.
REQ-006 AW inputs SHALL be: awaddr ADDR_W, awlen 8, awsize 3, awburst 2, awvalid 1, awready 1.
REQ-007 W inputs SHALL be: wdata DATA_W, wstrb STRB_W, wlast 1, wvalid 1, wready 1.
REQ-008 B inputs SHALL be: bresp 2, bvalid 1, bready 1.
REQ-009 AR inputs SHALL be: araddr ADDR_W, arlen 8, arsize 3, arburst 2, arvalid 1, arready 1.
REQ-010 R inputs SHALL be: rdata DATA_W, rresp 2, rlast 1, rvalid 1, rready 1.
REQ-011 Port err_now: output, 16 bits; registered one-cycle pulse per violated rule.
REQ-012 Port err_flags: output, 16 bits; sticky OR of err_now.
REQ-013 Port err_count: output, 16 bits; saturating count of cycles with any violation.

Function
REQ-014 A handshake SHALL be defined as valid&&ready at a rising edge; a stall SHALL be defined as valid&&!ready.
REQ-015 A rule violated by the inputs sampled at edge N SHALL set its err_now bit after edge N, visible in cycle N+1; err_now SHALL otherwise be 0.
REQ-016 Bits 0-4 (AW/W/B/AR/R stability): after a stall at edge N-1, the channel SHALL violate its bit if, at edge N, valid is low or any payload differs.
REQ-017 AW payload is addr/len/size/burst; W payload is data/strb/last; B payload is resp; AR payload is addr/len/size/burst; R payload is data/resp/last.
REQ-018 Bits 5/6: awvalid/arvalid with burst==2'b11 (reserved) SHALL be a violation.
REQ-019 Bits 7/8: awvalid/arvalid with (1<<size) > STRB_W SHALL be a violation.
REQ-020 Bits 9/10: a WRAP burst (2'b10) SHALL be a violation if len is not in {1,3,7,15}, or if addr is not aligned to 1<<size.
REQ-021 Bits 11/12: an INCR burst (2'b01) SHALL be a violation if addr[11:0] + ((len+1)<<size) > 4096, computed in 17 bits.
REQ-022 Bits 11/12: FIXED bursts SHALL be exempt from the 4KB check.
REQ-023 Rule checks on the AW/AR channels SHALL be evaluated every valid cycle, not only at handshake.
REQ-024 An AW handshake SHALL push awlen into the AW len FIFO; an AR handshake SHALL push arlen into the AR len FIFO.
REQ-025 Bit 13 (WLAST): the W beat counter SHALL count W handshakes.
REQ-026 Bit 13: on a W handshake the expected len is the AW FIFO head, or the same-cycle AW handshake's awlen if the FIFO is empty.
REQ-027 Bit 13: wlast with beat count != expected len SHALL be a violation.
REQ-028 Bit 13: !wlast with beat count == expected len SHALL be a violation.
REQ-029 Bit 13: a wlast handshake with no expected len available SHALL be a violation.
REQ-030 Bit 13: a wlast handshake SHALL clear the beat counter, pop the FIFO, and increment the write-done counter.
REQ-031 Bit 14 (RLAST): R beats SHALL be checked by the same rules against the AR FIFO.
REQ-032 Bit 14: rvalid while the AR FIFO is empty and no same-cycle AR handshake occurs SHALL be a violation.
REQ-033 Bit 15: bvalid while write-done==0 and no same-cycle wlast handshake occurs SHALL be a violation.
REQ-034 Bit 15: a push into a full FIFO (DEPTH entries) SHALL be a violation, and the push SHALL be dropped.
REQ-035 A B handshake SHALL decrement write-done; the counter SHALL saturate at 0 and at DEPTH.
REQ-036 Simultaneous push and pop on a full FIFO SHALL succeed without a violation.
REQ-037 err_count SHALL increment by 1 per cycle in which err_now is nonzero, and SHALL hold at 16'hFFFF.

Reset
REQ-038 While areset is high, all checks SHALL be suppressed.
REQ-039 While areset is high, err_now, err_flags and err_count SHALL be 0.
REQ-040 While areset is high, FIFOs, beat counters, write-done and stall history SHALL be cleared.
REQ-041 Reset asserted mid-burst SHALL discard all tracking; checking SHALL resume on the first edge after areset falls.

Structure
REQ-042 Package axi4_assertion_pkg SHALL hold burst encodings (FIXED=0, INCR=1, WRAP=2), resp codes, and the 16 error-bit index constants.
REQ-043 Sub-module axi4_len_fifo (8-bit entries, DEPTH, push/pop/full/empty/head) SHALL be instantiated twice, for AW and AR.

Verification
REQ-044 Legal INCR write (addr 0x100, len 3, size 2) with 4 W beats, wlast on beat 4, then one B -> err_flags stays 0.
REQ-045 awvalid stalled 2 cycles with awaddr changing 0x100->0x104 -> err_now[0] pulses once, err_flags[0]=1, err_count=1.
REQ-046 AR INCR addr 0xFF0, len 7, size 2 (ends 0x1010) -> bit 12 set; the same request at addr 0xF00 -> no error.
REQ-047 WRAP write, len 2 -> bit 9 set; WRAP addr 0x102, size 2, len 3 -> bit 9 set.
REQ-048 Read len 3 with rlast on beat 3 -> bit 14; rvalid with no AR outstanding -> bit 14; bvalid before any wlast -> bit 15.
REQ-049 Violations followed by areset high for 1 cycle -> all outputs 0; a subsequent legal traffic run keeps them 0.
